alu_dispatch: RTL and testbench

- Initiator/consumer side of the combinational ALU interface for the RV32I integer datapath.
- Accepts decoded-register-read instructions on a valid/ready handshake and decodes opcode/funct3/funct7 into ALU operand, operation and switch controls.
- Drives an external ALU instance from a registered issue stage, then captures the ALU result and flags into a registered writeback stage.
- Evaluates branch conditions from the ALU outputs; backpressure propagates through both stages.

---
 rtl/alu_dispatch_pkg.sv | 34 +++
 rtl/alu_dispatch_decode.sv | 64 ++++++
 rtl/alu_dispatch.sv | 82 ++++++++
 tb/tb_alu_dispatch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_dispatch_pkg.sv
// alu_dispatch_pkg: shared opcodes, ALU op codes and stage-1 payload for alu_dispatch
package alu_dispatch_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        sw;
    logic [4:0]  rd;
    logic        we;
    logic        branch;
    logic [1:0]  cond;
    logic [31:0] target;
    logic        illegal;
  } s1_t;
endpackage

// File: rtl/alu_dispatch_decode.sv
// alu_dispatch_decode: combinational RV32I decode of instr/pc/rs into the stage-1 payload
module alu_dispatch_decode
  import alu_dispatch_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output s1_t         p
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic [31:0] i_imm, u_imm, b_imm;
  logic ill;
  assign opc = instr[6:0];
  assign rd = instr[11:7];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign u_imm = {instr[31:12], 12'b0};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  always_comb begin
    p = '0;
    ill = 1'b0;
    p.rd = rd;
    p.a = rs1;
    p.b = rs2;
    p.op = f3;
    case (opc)
      OPC_OP: begin
        p.sw = f7[5];
        ill = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == ALU_ADD || f3 == ALU_SR)));
      end
      OPC_OPIMM: begin
        p.b = i_imm;
        p.sw = (f3 == ALU_SR) & instr[30];
        ill = (f3 == ALU_SLL && f7 != 7'b0) || (f3 == ALU_SR && f7 != 7'b0 && f7 != 7'b0100000);
      end
      OPC_LUI: begin
        p.a = '0;
        p.b = u_imm;
        p.op = ALU_ADD;
      end
      OPC_AUIPC: begin
        p.a = pc;
        p.b = u_imm;
        p.op = ALU_ADD;
      end
      OPC_BRANCH: begin
        p.op = (f3 == F3_BLTU || f3 == F3_BGEU) ? ALU_SLTU : (f3 == F3_BLT || f3 == F3_BGE) ? ALU_SLT : ALU_ADD;
        p.sw = (f3 == F3_BEQ || f3 == F3_BNE);
        p.branch = 1'b1;
        p.cond = {f3[2], f3[0]};
        p.target = pc + b_imm;
        ill = !(f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
      end
      default: ill = 1'b1;
    endcase
    p.we = !ill && !p.branch && rd != 5'd0;
    p.illegal = ill;
    if (ill) p = '{rd: rd, illegal: 1'b1, default: '0};
  end
endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: two-stage issue/writeback pipeline driving an external combinational ALU
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic            alu_switch,
  input  logic [XLEN-1:0] alu_o,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic            alu_v,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_branch,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);
  s1_t dec, s1;
  logic s1_valid, s2_adv, s1_adv, unused;
  assign s2_adv = !out_valid | out_ready;
  assign s1_adv = !s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign alu_a = s1.a;
  assign alu_b = s1.b;
  assign alu_op = s1.op;
  assign alu_switch = s1.sw;
  assign unused = ^{alu_n, alu_v};
  alu_dispatch_decode u_decode (
    .instr(in_instr),
    .pc   (in_pc),
    .rs1  (in_rs1),
    .rs2  (in_rs2),
    .p    (dec)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1 <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1 <= dec;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_result <= '0;
      out_rd <= '0;
      out_we <= 1'b0;
      out_branch <= 1'b0;
      out_taken <= 1'b0;
      out_target <= '0;
      out_illegal <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= s1.illegal ? '0 : alu_o;
        out_rd <= s1.rd;
        out_we <= s1.we;
        out_branch <= s1.branch;
        out_taken <= s1.branch & ((s1.cond[1] ? alu_o[0] : alu_z) ^ s1.cond[0]);
        out_target <= s1.target;
        out_illegal <= s1.illegal;
      end
    end
  end
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: randomized and directed checks of alu_dispatch against an instruction-level model
module tb_alu_dispatch;
  logic clk = 1'b0, reset_n;
  logic in_valid, in_ready, alu_switch, alu_z, alu_n, alu_v;
  logic out_valid, out_ready, out_we, out_branch, out_taken, out_illegal;
  logic [31:0] in_instr, in_pc, in_rs1, in_rs2, alu_a, alu_b, alu_o, out_result, out_target;
  logic [2:0] alu_op;
  logic [4:0] out_rd;
  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we, branch, taken, illegal;
    logic [31:0] target;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0, cyc = 0, drains = 0, drain_cyc = 0;
  logic acc, stall_prev, busy_prev;
  logic [2:0] smp_op;
  logic smp_sw;
  exp_t last, hold;
  logic [31:0] h_a, h_b;
  logic [2:0] h_op;
  logic h_sw;
  always #5 clk = ~clk;
  alu_dispatch dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_switch(alu_switch), .alu_o(alu_o), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_we(out_we), .out_branch(out_branch), .out_taken(out_taken), .out_target(out_target),
    .out_illegal(out_illegal)
  );
  function automatic logic [31:0] alu_ref(logic [2:0] op, logic sw, logic [31:0] a, logic [31:0] b);
    case (op)
      3'd0: return sw ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'b0, $signed(a) < $signed(b)};
      3'd3: return {31'b0, a < b};
      3'd4: return a ^ b;
      3'd5: return sw ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction
  always_comb begin
    alu_o = alu_ref(alu_op, alu_switch, alu_a, alu_b);
    alu_z = alu_o == 32'b0;
    alu_n = alu_o[31];
    alu_v = alu_op == 3'd0 && (alu_switch ? alu_a[31] != alu_b[31] : alu_a[31] == alu_b[31]) && alu_o[31] != alu_a[31];
  end
  function automatic exp_t model(logic [31:0] instr, logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2);
    exp_t e;
    logic [6:0] opc = instr[6:0], f7 = instr[31:25];
    logic [2:0] f3 = instr[14:12];
    logic [31:0] imm_i = {{20{instr[31]}}, instr[31:20]};
    logic [31:0] imm_u = {instr[31:12], 12'b0};
    logic [31:0] imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    logic ok = 1'b1;
    e = '{result: 0, rd: instr[11:7], we: 0, branch: 0, taken: 0, illegal: 0, target: 0};
    case (opc)
      7'b0110011: begin
        ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.result = alu_ref(f3, f7[5], rs1, rs2);
      end
      7'b0010011: begin
        ok = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        e.result = alu_ref(f3, f3 == 3'd5 && instr[30], rs1, imm_i);
      end
      7'b0110111: e.result = imm_u;
      7'b0010111: e.result = pc + imm_u;
      7'b1100011: begin
        ok = f3 != 3'd2 && f3 != 3'd3;
        e.branch = 1'b1;
        e.target = pc + imm_b;
        case (f3)
          3'd0: e.taken = rs1 == rs2;
          3'd1: e.taken = rs1 != rs2;
          3'd4: e.taken = $signed(rs1) < $signed(rs2);
          3'd5: e.taken = $signed(rs1) >= $signed(rs2);
          3'd6: e.taken = rs1 < rs2;
          default: e.taken = rs1 >= rs2;
        endcase
        e.result = !f3[2] ? rs1 - rs2 : f3[1] ? {31'b0, rs1 < rs2} : {31'b0, $signed(rs1) < $signed(rs2)};
      end
      default: ok = 1'b0;
    endcase
    if (!ok) e = '{result: 0, rd: instr[11:7], we: 0, branch: 0, taken: 0, illegal: 1, target: 0};
    else e.we = !e.branch && e.rd != 5'd0;
    return e;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    exp_t e;
    #1;
    if (stall_prev) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_result", out_result, hold.result);
      chk("hold_rd", out_rd, hold.rd);
      chk("hold_taken", out_taken, hold.taken);
      chk("hold_target", out_target, hold.target);
    end
    if (busy_prev) begin
      chk("hold_alu_a", alu_a, h_a);
      chk("hold_alu_b", alu_b, h_b);
      chk("hold_alu_op", alu_op, h_op);
      chk("hold_alu_sw", alu_switch, h_sw);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("result", out_result, e.result);
        chk("rd", out_rd, e.rd);
        chk("we", out_we, e.we);
        chk("branch", out_branch, e.branch);
        chk("taken", out_taken, e.taken);
        chk("target", out_target, e.target);
        chk("illegal", out_illegal, e.illegal);
      end
      drains++;
      drain_cyc = cyc;
      last = '{result: out_result, rd: out_rd, we: out_we, branch: out_branch, taken: out_taken, illegal: out_illegal, target: out_target};
    end
    stall_prev = out_valid && !out_ready;
    busy_prev = !in_ready;
    hold = '{result: out_result, rd: out_rd, we: out_we, branch: out_branch, taken: out_taken, illegal: out_illegal, target: out_target};
    h_a = alu_a; h_b = alu_b; h_op = alu_op; h_sw = alu_switch;
    smp_op = alu_op; smp_sw = alu_switch;
    acc = in_valid && in_ready;
    if (acc) q.push_back(model(in_instr, in_pc, in_rs1, in_rs2));
    cyc++;
    @(negedge clk);
  endtask
  task automatic directed(string tag, logic [31:0] instr, logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2,
                          logic [31:0] res, logic we, logic br, logic tk, logic [31:0] tg, logic ill,
                          logic [2:0] op, logic sw);
    int c0, d0;
    in_instr = instr; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
    in_valid = 1'b1; out_ready = 1'b1;
    c0 = cyc; d0 = drains;
    tick();
    chk({tag, "_accept"}, acc, 1);
    in_valid = 1'b0;
    tick();
    if (!ill) begin
      chk({tag, "_alu_op"}, smp_op, op);
      chk({tag, "_alu_sw"}, smp_sw, sw);
    end
    for (int n = 0; n < 8 && drains == d0; n++) tick();
    chk({tag, "_latency"}, drain_cyc - c0, 2);
    chk({tag, "_res"}, last.result, res);
    chk({tag, "_we"}, last.we, we);
    chk({tag, "_branch"}, last.branch, br);
    chk({tag, "_taken"}, last.taken, tk);
    chk({tag, "_target"}, last.target, tg);
    chk({tag, "_illegal"}, last.illegal, ill);
  endtask
  function automatic logic [31:0] b_type(logic [12:0] imm, logic [4:0] r2, logic [4:0] r1, logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] edge_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction
  function automatic logic [31:0] rnd_instr();
    logic [31:0] r = $urandom;
    logic [6:0] opc, f7;
    case ($urandom_range(0, 6))
      0, 1: opc = 7'b0110011;
      2: opc = 7'b0010011;
      3: opc = 7'b0110111;
      4: opc = 7'b0010111;
      5: opc = 7'b1100011;
      default: opc = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0, 1: f7 = 7'h00;
      2: f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], opc};
  endfunction
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int d0, ptr;
    logic saw_low;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0;
    stall_prev = 0; busy_prev = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", out_result, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    reset_n = 1'b1;
    directed("add", 32'h002081B3, 0, 32'h7FFFFFFF, 1, 32'h80000000, 1, 0, 0, 0, 0, 3'b000, 0);
    directed("srai", {7'b0100000, 5'd4, 5'd4, 3'b101, 5'd5, 7'b0010011}, 0, 32'hF0000000, 0,
             32'hFF000000, 1, 0, 0, 0, 0, 3'b101, 1);
    directed("blt", b_type(13'h1FF8, 5'd2, 5'd1, 3'b100), 32'h100, 32'hFFFFFFFF, 1, 1, 0, 1, 1, 32'hF8, 0, 3'b010, 0);
    directed("bltu", b_type(13'h1FF8, 5'd2, 5'd1, 3'b110), 32'h100, 32'hFFFFFFFF, 1, 0, 0, 1, 0, 32'hF8, 0, 3'b011, 0);
    directed("beq", b_type(13'h0010, 5'd2, 5'd1, 3'b000), 32'h200, 32'h5, 32'h5, 0, 0, 1, 1, 32'h210, 0, 3'b000, 1);
    directed("load", {12'h004, 5'd1, 3'd2, 5'd7, 7'b0000011}, 0, 32'h11, 32'h22, 0, 0, 0, 0, 0, 1, 3'b000, 0);
    directed("op_f7_1", {7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011}, 0, 32'h11, 32'h22, 0, 0, 0, 0, 0, 1, 3'b000, 0);
    directed("add_x0", {7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'b0110011}, 0, 3, 4, 7, 0, 0, 0, 0, 0, 3'b000, 0);
    d0 = drains; ptr = 0; saw_low = 0;
    for (int k = 0; k < 40 && (ptr < 4 || q.size() > 0); k++) begin
      in_valid = ptr < 4;
      in_instr = {7'h00, 5'd2, 5'd1, 3'd0, 5'(ptr + 1), 7'b0110011};
      in_rs1 = 32'(ptr) * 32'h1000; in_rs2 = 32'(ptr) + 32'h10;
      out_ready = !(k >= 2 && k < 5);
      tick();
      if (busy_prev) saw_low = 1;
      if (acc) ptr++;
    end
    chk("stream_ready_low", saw_low, 1);
    chk("stream_sent", ptr, 4);
    chk("stream_drained", drains - d0, 4);
    for (int k = 0; k < 400; k++) begin
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      in_instr = rnd_instr(); in_pc = $urandom; in_rs1 = edge_val(); in_rs2 = edge_val();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() > 0; n++) tick();
    chk("random_drained", q.size(), 0);
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h002081B3; in_rs1 = 32'h1234; in_rs2 = 32'h1;
    tick();
    tick();
    #1;
    chk("prerst_out_valid", out_valid, 1);
    chk("prerst_in_ready", in_ready, 0);
    reset_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_result", out_result, 0);
    chk("midrst_rd", out_rd, 0);
    chk("midrst_we", out_we, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_b", alu_b, 0);
    chk("midrst_alu_op", alu_op, 0);
    q.delete(); stall_prev = 0; busy_prev = 0;
    reset_n = 1'b1; out_ready = 1'b1;
    d0 = drains;
    @(negedge clk);
    repeat (3) tick();
    chk("postrst_no_output", drains - d0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
